// File: rtl/gray_bin_converter.sv
// rtl/gray_bin_converter.sv - registered Gray<->binary converter with Gray single-step checker
// One-deep output register with valid/ready handshake; optional step checker and error counter.
module gray_bin_converter #(
  parameter int WIDTH    = 8,
  parameter int CNT_W    = 8,
  parameter int CHECK_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_mode,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             clr_err
);

  logic             accept;
  logic [WIDTH-1:0] conv_data;

  function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = g[i] ^ b[i+1];
    end
    return b;
  endfunction

  assign in_ready  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  assign conv_data = in_mode ? (in_data ^ (in_data >> 1)) : gray_to_bin(in_data);

  // Output beat register; data holds whenever no new word is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_mode  <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= conv_data;
      out_mode  <= in_mode;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  generate
    if (CHECK_EN != 0) begin : g_check
      localparam logic [WIDTH-1:0] W_ONE   = WIDTH'(1);
      localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
      localparam logic [CNT_W-1:0] CNT_MAX = '1;

      logic [WIDTH-1:0] prev_gray;
      logic             prev_vld;
      logic [CNT_W-1:0] cnt;
      logic             err_q;
      logic [WIDTH-1:0] diff;
      logic             single_step;
      logic             flag;

      // Exactly one differing bit: nonzero and a power of two.
      assign diff        = in_data ^ prev_gray;
      assign single_step = (diff != '0) && ((diff & (diff - W_ONE)) == '0);
      assign flag        = !in_mode && prev_vld && !single_step;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          prev_gray <= '0;
          prev_vld  <= 1'b0;
          cnt       <= '0;
          err_q     <= 1'b0;
        end else begin
          if (accept) begin
            err_q <= flag;
          end
          if (clr_err) begin
            cnt <= '0;
          end else if (accept && flag && cnt != CNT_MAX) begin
            cnt <= cnt + C_ONE;
          end
          // A Gray accept reloads history even when a clear arrives in the same cycle.
          if (accept && !in_mode) begin
            prev_gray <= in_data;
            prev_vld  <= 1'b1;
          end else if (accept || clr_err) begin
            prev_vld  <= 1'b0;
          end
        end
      end

      assign step_err  = err_q;
      assign err_count = cnt;
    end else begin : g_nocheck
      assign step_err  = 1'b0;
      assign err_count = '0;
    end
  endgenerate

endmodule

// File: tb/tb_gray_bin_converter.sv
// tb/tb_gray_bin_converter.sv - self-checking bench for gray_bin_converter
// Three instances share stimulus: default counter, 2-bit counter, checker disabled.
module tb_gray_bin_converter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_mode = 1'b0;
  logic       out_ready = 1'b0;
  logic       clr_err = 1'b0;

  logic       in_ready_a, out_valid_a, out_mode_a, step_err_a;
  logic [7:0] out_data_a, err_count_a;
  logic       in_ready_b, out_valid_b, out_mode_b, step_err_b;
  logic [7:0] out_data_b;
  logic [1:0] err_count_b;
  logic       in_ready_c, out_valid_c, out_mode_c, step_err_c;
  logic [7:0] out_data_c, err_count_c;

  gray_bin_converter #(.WIDTH(8), .CNT_W(8), .CHECK_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_data(out_data_a), .out_mode(out_mode_a), .step_err(step_err_a),
    .err_count(err_count_a), .clr_err(clr_err));

  gray_bin_converter #(.WIDTH(8), .CNT_W(2), .CHECK_EN(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_data(out_data_b), .out_mode(out_mode_b), .step_err(step_err_b),
    .err_count(err_count_b), .clr_err(clr_err));

  gray_bin_converter #(.WIDTH(8), .CNT_W(8), .CHECK_EN(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_c), .out_ready(out_ready),
    .out_data(out_data_c), .out_mode(out_mode_c), .step_err(step_err_c),
    .err_count(err_count_c), .clr_err(clr_err));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_mode;
  logic       m_err;
  int         m_cnt;
  logic [7:0] m_pgray;
  logic       m_pvld;

  // Each binary bit is the parity of the Gray bits at and above it.
  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    for (int i = 0; i < 8; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  function automatic logic [7:0] b2g(input logic [7:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int sat(input int c, input int mx);
    return (c > mx) ? mx : c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_data = 8'h00; m_mode = 1'b0; m_err = 1'b0;
    m_cnt = 0; m_pgray = 8'h00; m_pvld = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ":out_valid"},   32'(out_valid_a), 32'(m_valid));
    chk({tag, ":out_data"},    32'(out_data_a),  32'(m_data));
    chk({tag, ":out_mode"},    32'(out_mode_a),  32'(m_mode));
    chk({tag, ":step_err"},    32'(step_err_a),  32'(m_err));
    chk({tag, ":err_count"},   32'(err_count_a), 32'(sat(m_cnt, 255)));
    chk({tag, ":b_out_data"},  32'(out_data_b),  32'(m_data));
    chk({tag, ":b_step_err"},  32'(step_err_b),  32'(m_err));
    chk({tag, ":b_err_count"}, 32'(err_count_b), 32'(sat(m_cnt, 3)));
    chk({tag, ":c_out_valid"}, 32'(out_valid_c), 32'(m_valid));
    chk({tag, ":c_out_data"},  32'(out_data_c),  32'(m_data));
    chk({tag, ":c_step_err"},  32'(step_err_c),  32'(0));
    chk({tag, ":c_err_count"}, 32'(err_count_c), 32'(0));
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic m,
                       input logic ordy, input logic clr);
    in_valid = v; in_data = d; in_mode = m; out_ready = ordy; clr_err = clr;
    #1;
  endtask

  task automatic cycle(input string tag);
    logic acc;
    logic flag;
    acc = in_valid && (!m_valid || out_ready);
    chk({tag, ":in_ready"}, 32'(in_ready_a), 32'(!m_valid || out_ready));
    @(posedge clk);
    #1;
    flag = acc && !in_mode && m_pvld && ($countones(in_data ^ m_pgray) != 1);
    if (clr_err) begin
      m_cnt = 0;
      m_pvld = 1'b0;
    end else if (flag) begin
      m_cnt++;
    end
    if (acc) begin
      m_valid = 1'b1;
      m_data  = in_mode ? b2g(in_data) : g2b(in_data);
      m_mode  = in_mode;
      m_err   = flag;
      if (!in_mode) begin
        m_pgray = in_data;
        m_pvld  = 1'b1;
      end else begin
        m_pvld  = 1'b0;
      end
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    check_outputs(tag);
  endtask

  initial begin
    logic [7:0] d;
    logic       m;
    model_reset();
    #3;
    check_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cycle("idle");

    // Known conversion pair
    drive(1'b1, 8'hE6, 1'b0, 1'b1, 1'b0);
    cycle("g2b_e6");
    chk("g2b_e6_const", 32'(out_data_a), 32'h0000_00BB);
    chk("g2b_e6_err", 32'(step_err_a), 32'(0));
    drive(1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
    cycle("b2g_bb");
    chk("b2g_bb_const", 32'(out_data_a), 32'h0000_00E6);
    chk("b2g_bb_mode", 32'(out_mode_a), 32'(1));
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0); cycle("walk0");
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0); cycle("walk1");
    drive(1'b1, 8'h03, 1'b0, 1'b1, 1'b0); cycle("walk3");
    chk("walk_cnt0", 32'(err_count_a), 32'(0));

    // Flagged jump and repeat, after a binary beat breaks history
    drive(1'b1, 8'h00, 1'b1, 1'b1, 1'b0); cycle("brk");
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0); cycle("seq00");
    chk("seq00_err", 32'(step_err_a), 32'(0));
    drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0); cycle("seq01");
    chk("seq01_err", 32'(step_err_a), 32'(0));
    drive(1'b1, 8'h07, 1'b0, 1'b1, 1'b0); cycle("seq07a");
    chk("seq07a_err", 32'(step_err_a), 32'(1));
    drive(1'b1, 8'h07, 1'b0, 1'b1, 1'b0); cycle("seq07b");
    chk("seq07b_err", 32'(step_err_a), 32'(1));
    chk("seq_cnt2", 32'(err_count_a), 32'(2));

    // Backpressure: hold three cycles, then pop and load on the same edge
    drive(1'b1, 8'h10, 1'b0, 1'b1, 1'b0); cycle("bp_load");
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
      cycle("bp_hold");
      chk("bp_in_ready", 32'(in_ready_a), 32'(0));
      chk("bp_stable", 32'(out_data_a), 32'(g2b(8'h10)));
    end
    drive(1'b1, 8'h11, 1'b0, 1'b1, 1'b0); cycle("bp_pop");
    chk("bp_next", 32'(out_data_a), 32'(g2b(8'h11)));
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); cycle("bp_drain");
    chk("bp_empty", 32'(out_valid_a), 32'(0));

    // Saturation of the 2-bit counter
    drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b1); cycle("sat_clr");
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0); cycle("sat_first");
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b0);
      cycle("sat_rep");
      chk("sat_b_count", 32'(err_count_b), 32'((k < 3) ? k + 1 : 3));
    end
    drive(1'b1, 8'h55, 1'b0, 1'b1, 1'b1); cycle("clr_flag");
    chk("clr_flag_err", 32'(step_err_a), 32'(1));
    chk("clr_flag_cnt_a", 32'(err_count_a), 32'(0));
    chk("clr_flag_cnt_b", 32'(err_count_b), 32'(0));

    // Reset while a beat is held under backpressure
    drive(1'b1, 8'h20, 1'b0, 1'b1, 1'b0); cycle("rst_load");
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0); cycle("rst_hold");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 8'hFF, 1'b0, 1'b1, 1'b0); cycle("post_ff");
    chk("post_ff_err", 32'(step_err_a), 32'(0));
    drive(1'b1, 8'h00, 1'b0, 1'b1, 1'b0); cycle("post_00");
    chk("post_00_err", 32'(step_err_a), 32'(1));

    // Randomized traffic: mix of single-bit walks, repeats and arbitrary jumps
    for (int n = 0; n < 400; n++) begin
      m = ($urandom_range(0, 7) == 0);
      case ($urandom_range(0, 3))
        0, 1: d = m_pgray ^ (8'h01 << $urandom_range(0, 7));
        2:    d = m_pgray;
        default: d = 8'($urandom);
      endcase
      drive($urandom_range(0, 3) != 0, d, m, $urandom_range(0, 3) != 0,
            $urandom_range(0, 19) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_bin_converter.md
GRAY_BIN_CONVERTER -- requirements
Module: gray_bin_converter

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>= 2).
REQ-002 Parameter CNT_W, default 8, width of the step-error counter.
REQ-003 Parameter CHECK_EN, default 1, 1 enables the Gray step checker; 0 removes it.
REQ-004 Clocking SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  upstream word present.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_data  input  WIDTH  word to convert.
REQ-010 in_mode  input  1  0 = Gray-to-binary, 1 = binary-to-Gray, sampled with in_data.
REQ-011 out_valid  output  1  converted word present.
REQ-012 out_ready  input  1  downstream accepts the output word.
REQ-013 out_data  output  WIDTH  converted word.
REQ-014 out_mode  output  1  in_mode of the beat currently on out_data.
REQ-015 step_err  output  1  beat on out_data failed the Gray single-bit-step check.
REQ-016 err_count  output  CNT_W  saturating count of flagged beats.
REQ-017 clr_err  input  1  synchronous clear of err_count and checker history.

Function
REQ-018 Accept SHALL occur when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-019 An accepted word SHALL appear on out_data with out_valid high exactly 1 cycle after the accept edge.
REQ-020 While out_valid && !out_ready, out_data, out_mode, step_err SHALL hold stable.
REQ-021 Simultaneous output pop and input accept SHALL replace the output beat with no bubble (full throughput).
REQ-022 out_valid SHALL deassert after a pop with no same-cycle accept.
REQ-023 Gray-to-binary: out[WIDTH-1] = in[WIDTH-1]; out[i] = in[i] ^ out[i+1] for i = WIDTH-2 down to 0.
REQ-024 Binary-to-Gray: out[WIDTH-1] = in[WIDTH-1]; out[i] = in[i] ^ in[i+1].
REQ-025 Checker state: prev_gray (WIDTH) and prev_vld (1).
REQ-026 On a Gray-to-binary accept: flag = prev_vld && (popcount(in_data ^ prev_gray) != 1); distance 0 (repeat) SHALL flag; then prev_gray <= in_data, prev_vld <= 1.
REQ-027 On a binary-to-Gray accept: flag = 0; prev_vld <= 0 (history broken by mode change).
REQ-028 step_err SHALL be registered with its beat and travel with out_data.
REQ-029 err_count SHALL increment by 1 per flagged accept and saturate at 2^CNT_W-1 (no wrap).
REQ-030 clr_err high: err_count <= 0 and prev_vld <= 0; a same-cycle flagged accept SHALL still assert step_err on its beat but SHALL NOT increment the count; a same-cycle Gray accept SHALL load prev_gray and set prev_vld <= 1 (load wins over clear for history).
REQ-031 CHECK_EN = 0: step_err and err_count SHALL be constant 0; prev_gray/prev_vld need not exist.
REQ-032 No accept SHALL occur while rst_n is low.

Reset
REQ-033 rst_n low SHALL immediately force out_valid = 0, out_data = 0, out_mode = 0, step_err = 0, err_count = 0, prev_vld = 0, prev_gray = 0.
REQ-034 Reset mid-transfer SHALL discard any held output beat; the first Gray word after release SHALL never flag.

Verification
REQ-035 WIDTH=8, mode 0, in_data 8'b11100110, out_ready=1 -> next cycle out_data 8'b10111011, out_valid=1, step_err=0.
REQ-036 Mode 1, in_data 8'b10111011 -> out_data 8'b11100110, out_mode=1; then mode 0 words 0x00, 0x01, 0x03 -> no flags, err_count 0.
REQ-037 Mode 0 sequence 0x00, 0x01, 0x07, 0x07 -> step_err 0, 0, 1, 1 on respective beats; err_count ends at 2.
REQ-038 out_ready low 3 cycles with in_valid high -> in_ready low, out_data stable; out_ready high -> one pop, next word loaded same edge, no loss or duplication.
REQ-039 CNT_W=2, six flagged beats -> err_count 1, 2, 3, 3, 3, 3; clr_err pulse coincident with a flagged accept -> step_err=1, err_count=0.
REQ-040 rst_n low while out_valid=1 and out_ready=0 -> outputs 0 immediately; after release, Gray word 0xFF then 0x00 -> first no flag, second flags (distance 8).
